// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Multi-cycle instruction fetch unit holding the architectural PC.
//            Define IFU_TIMEOUT_EN to enable the sticky fetch-timeout fault.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int unsigned          ISA_WIDTH      = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_PC       = ISA_WIDTH'(32'h8000_0000),
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter int unsigned          TIMEOUT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ISA_WIDTH-1:0] pc_in,
    input  logic                 pc_w_en,
    output logic [ISA_WIDTH-1:0] pc_out,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [ISA_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [ISA_WIDTH-1:0] imem_resp_data,
    output logic [ISA_WIDTH-1:0] inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 fault
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_hold  = 3'd3;
    localparam logic [2:0] c_st_fault = 3'd4;

    logic [2:0]           r_state;
    logic [ISA_WIDTH-1:0] r_pc;
    logic [ISA_WIDTH-1:0] r_inst;
    logic                 r_inst_valid;
    logic                 r_req_valid;
    logic [ISA_WIDTH-1:0] w_pc_next;

    // Redirect targets are forced word-aligned; sequential flow wraps naturally.
    assign w_pc_next = pc_w_en ? {pc_in[ISA_WIDTH-1:2], 2'b00} : r_pc + ISA_WIDTH'(4);

    assign pc_out         = r_pc;
    assign imem_req_addr  = r_pc;
    assign imem_req_valid = r_req_valid;
    assign inst           = r_inst;
    assign inst_valid     = r_inst_valid;

`ifdef IFU_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] c_tmo_last = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] r_tmo;
    logic                 r_fault;
    logic                 w_tmo_hit;
    logic                 w_unused_cfg;

    // Hitting TIMEOUT_CYCLES-1 here means this edge completes the full budget.
    assign w_tmo_hit    = (r_tmo == c_tmo_last);
    assign fault        = r_fault;
    assign w_unused_cfg = ^pc_in[1:0];
`else
    logic w_unused_cfg;

    assign fault        = 1'b0;
    assign w_unused_cfg = ^{pc_in[1:0], TIMEOUT_CYCLES[0], TIMEOUT_W[0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_req_valid  <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            r_tmo        <= '0;
            r_fault      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_state     <= c_st_req;
                    r_req_valid <= 1'b1;
`ifdef IFU_TIMEOUT_EN
                    r_tmo       <= '0;
`endif
                end
                c_st_req: begin
                    if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= c_st_wait;
                    end
`ifdef IFU_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_req_valid <= 1'b0;
                        r_fault     <= 1'b1;
                        r_state     <= c_st_fault;
                    end
                    r_tmo <= r_tmo + TIMEOUT_W'(1);
`endif
                end
                c_st_wait: begin
                    if (imem_resp_valid) begin
                        r_inst       <= imem_resp_data;
                        r_inst_valid <= 1'b1;
                        r_state      <= c_st_hold;
                    end
`ifdef IFU_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_fault <= 1'b1;
                        r_state <= c_st_fault;
                    end
                    r_tmo <= r_tmo + TIMEOUT_W'(1);
`endif
                end
                c_st_hold: begin
                    if (r_inst_valid && inst_ready) begin
                        r_pc         <= w_pc_next;
                        r_inst_valid <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_state      <= c_st_req;
`ifdef IFU_TIMEOUT_EN
                        r_tmo        <= '0;
`endif
                    end
                end
                c_st_fault: begin
                    // Sticky: only reset leaves this state.
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_state      <= c_st_idle;
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Directed self-checking bench for ifu_fetch (both IFU_TIMEOUT_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_w_en;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch #(
        .ISA_WIDTH      (32),
        .RESET_PC       (32'h8000_0000),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_W      (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_w_en         (pc_w_en),
        .pc_out          (pc_out),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs driven after this apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From REQ: handshake, deliver one word, land in HOLD.
    task automatic fetch_word(input logic [31:0] data);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        step();
        imem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        n_checks++; if (pc_out !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want 80000000", pc_out); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
        rst = 1'b1;
        step();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            n_fail++; $display("FAIL first_req: got valid=%b addr=%h want 1/80000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_sequential();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL seq_wait: got req_valid=%b inst_valid=%b want 0/0", imem_req_valid, inst_valid); end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0513;
        step();
        imem_resp_valid = 1'b0;
        n_checks++; if (inst !== 32'h0000_0513 || inst_valid !== 1'b1) begin
            n_fail++; $display("FAIL seq_inst: got %h/%b want 00000513/1", inst, inst_valid); end
        inst_ready = 1'b1;
        pc_w_en    = 1'b0;
        step();
        inst_ready = 1'b0;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL seq_next: got valid=%b addr=%h iv=%b want 1/80000004/0", imem_req_valid, imem_req_addr, inst_valid); end
    endtask

    task automatic test_redirect();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        pc_w_en = 1'b1;
        pc_in   = 32'h1234_5678;
        step();
        n_checks++; if (pc_out !== 32'h8000_0004) begin n_fail++; $display("FAIL redirect_in_wait: got %h want 80000004", pc_out); end
        pc_w_en = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        step();
        imem_resp_valid = 1'b0;
        n_checks++; if (inst !== 32'h0010_0093 || pc_out !== 32'h8000_0004) begin
            n_fail++; $display("FAIL redirect_inst: got %h pc %h want 00100093/80000004", inst, pc_out); end
        pc_w_en    = 1'b1;
        pc_in      = 32'h8000_0103;
        inst_ready = 1'b1;
        step();
        pc_w_en    = 1'b0;
        inst_ready = 1'b0;
        n_checks++; if (imem_req_addr !== 32'h8000_0100 || imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL redirect_target: got %h/%b want 80000100/1", imem_req_addr, imem_req_valid); end
    endtask

    task automatic test_back_pressure();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
                n_fail++; $display("FAIL req_stall[%0d]: got %b/%h want 1/80000100", i, imem_req_valid, imem_req_addr); end
        end
        fetch_word(32'hDEAD_BEEF);
        pc_w_en = 1'b1;
        pc_in   = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (inst !== 32'hDEAD_BEEF || pc_out !== 32'h8000_0100 || imem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin
                n_fail++; $display("FAIL hold_stall[%0d]: got inst=%h pc=%h rv=%b iv=%b want deadbeef/80000100/0/1",
                                   i, inst, pc_out, imem_req_valid, inst_valid); end
        end
        pc_w_en    = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_checks++; if (imem_req_addr !== 32'h8000_0104) begin n_fail++; $display("FAIL stall_commit: got %h want 80000104", imem_req_addr); end
    endtask

    task automatic test_wrap();
        fetch_word(32'h0000_0013);
        pc_w_en    = 1'b1;
        pc_in      = 32'hFFFF_FFFF;
        inst_ready = 1'b1;
        step();
        pc_w_en    = 1'b0;
        inst_ready = 1'b0;
        n_checks++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_redirect: got %h want fffffffc", pc_out); end
        fetch_word(32'h0000_0013);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        n_checks++; if (pc_out !== 32'h0000_0000 || imem_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL wrap_seq: got %h/%b want 00000000/1", pc_out, imem_req_valid); end
    endtask

    task automatic test_reset_mid_wait();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        n_checks++; if (pc_out !== 32'h8000_0000 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL midwait_reset: got pc=%h rv=%b iv=%b want 80000000/0/0", pc_out, imem_req_valid, inst_valid); end
        rst = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hAAAA_5555;
        step();
        imem_resp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            n_fail++; $display("FAIL midwait_restart: got iv=%b inst=%h rv=%b addr=%h want 0/0/1/80000000",
                               inst_valid, inst, imem_req_valid, imem_req_addr); end
    endtask

`ifdef IFU_TIMEOUT_EN
    task automatic test_timeout();
        imem_req_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            n_checks++; if (fault !== 1'b0 || imem_req_valid !== 1'b1) begin
                n_fail++; $display("FAIL timeout_early[%0d]: got fault=%b rv=%b want 0/1", k, fault, imem_req_valid); end
        end
        step();
        n_checks++; if (fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 32'h8000_0000) begin
            n_fail++; $display("FAIL timeout_fault: got fault=%b rv=%b iv=%b pc=%h want 1/0/0/80000000",
                               fault, imem_req_valid, inst_valid, pc_out); end
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        repeat (4) step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        n_checks++; if (fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL fault_sticky: got fault=%b rv=%b iv=%b want 1/0/0", fault, imem_req_valid, inst_valid); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_reset: got %b want 0", fault); end
    endtask
`else
    task automatic test_timeout();
        int seen_fault = 0;
        imem_req_ready = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (fault !== 1'b0 || imem_req_valid !== 1'b1) seen_fault++;
        end
        n_checks++; if (seen_fault != 0) begin n_fail++; $display("FAIL no_timeout: got %0d bad cycles want 0", seen_fault); end
        n_checks++; if (imem_req_addr !== 32'h8000_0000 || fault !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout_state: got addr=%h fault=%b want 80000000/0", imem_req_addr, fault); end
    endtask
`endif

    initial begin
        rst             = 1'b0;
        pc_in           = '0;
        pc_w_en         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b0;
        test_reset();
        test_sequential();
        test_redirect();
        test_back_pressure();
        test_wrap();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
